// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared size encodings, error codes and FSM states for the load/store unit
package mem_ctrl_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;
    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BADSIZE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication, load extraction and alignment check
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  ea,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{ea, 3'b000} +: 8];
        h = ea[1] ? rdata[31:16] : rdata[15:0];
        be = size == SZ_BYTE ? 4'b0001 << ea :
             size == SZ_HALF ? (ea[1] ? 4'b1100 : 4'b0011) :
             size == SZ_WORD ? 4'b1111 : 4'b0000;
        wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                    size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        rdata_ext = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                    size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
        misalign = (size == SZ_HALF && ea[0]) || (size == SZ_WORD && ea != 2'b00);
    end
endmodule

// File: rtl/mem_control.sv
// mem_control: single-outstanding load/store unit with req/ack memory handshake and wait-state timeout
module mem_control
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic              op_signed,
    input  logic [31:0]       op_base,
    input  logic [11:0]       op_offset,
    input  logic [31:0]       op_wdata,
    input  logic [3:0]        op_dest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              err_valid,
    output logic [1:0]        err_code
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, nxt;
    logic [31:0]   ea, wrep, rext;
    logic [1:0]    lat_lo, lat_size, sel_lo, sel_size;
    logic          lat_sgn, sel_sgn, mis, bad, tmo, accept;
    logic [3:0]    be, dest;
    logic [CW-1:0] cnt;
    assign ea       = op_base + {{20{op_offset[11]}}, op_offset};
    assign sel_lo   = state == IDLE ? ea[1:0] : lat_lo;
    assign sel_size = state == IDLE ? op_size : lat_size;
    assign sel_sgn  = state == IDLE ? op_signed : lat_sgn;
    mem_lane_align u_align (
        .ea        (sel_lo),
        .size      (sel_size),
        .sgn       (sel_sgn),
        .wdata     (op_wdata),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext),
        .misalign  (mis)
    );
    assign bad      = op_size == SZ_RSVD || mis;
    assign accept   = op_valid && state == IDLE;
    assign tmo      = !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign op_ready = state == IDLE;
    assign mem_req  = state == ACCESS;
    assign wb_valid = state == WB;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    always_comb begin
        nxt = state == IDLE   ? (accept && !bad ? ACCESS : IDLE) :
              state == ACCESS ? (mem_ack ? (mem_we ? IDLE : WB) : (tmo ? IDLE : ACCESS)) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            cnt       <= '0;
            dest      <= '0;
            lat_lo    <= '0;
            lat_size  <= '0;
            lat_sgn   <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (accept && bad) begin
                err_valid <= 1'b1;
                err_code  <= op_size == SZ_RSVD ? ERR_BADSIZE : ERR_MISALIGN;
            end
            if (accept && !bad) begin
                mem_we    <= op_store;
                mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
                mem_be    <= be;
                mem_wdata <= wrep;
                dest      <= op_dest;
                lat_lo    <= ea[1:0];
                lat_size  <= op_size;
                lat_sgn   <= op_signed;
                cnt       <= '0;
            end
            if (state == ACCESS && mem_ack && !mem_we) begin
                wb_addr <= dest;
                wb_data <= rext;
            end
            if (state == ACCESS && !mem_ack) cnt <= cnt + 1'b1;
            if (state == ACCESS && tmo) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end
        end
    end
endmodule

// File: doc/mem_control.md
Name: mem_control

Overview:
- Load/store unit directly downstream of register_bank.
- Consumes the two read operands: DataOut1 is the base address and DataOut2 is the store data. Adds a signed offset from the instruction and runs one data-memory transaction using a req/ack handshake.
- Returns load results as a write-back (register number plus data) toward the register bank write port.
- Multi-cycle: one operation in flight at a time, with a wait-state timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req stays high without mem_ack before aborting (min 1)
ADDR_W, 32, data-memory byte address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_ready  out  1  unit idle, can accept
op_store  in  1  1=store, 0=load
op_size  in  2  00 byte, 01 half, 10 word, 11 reserved
op_signed  in  1  load sign-extend (ignored for word/store)
op_base  in  32  base address (register_bank DataOut1)
op_offset  in  12  signed byte offset
op_wdata  in  32  store data (register_bank DataOut2), value in low bits
op_dest  in  4  load destination register
mem_req  out  1  memory request, held until ack
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address (bits[1:0]=00)
mem_be  out  4  byte enables, bit k = byte lane k (little-endian)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes (read data valid same cycle)
mem_rdata  in  32  read data
wb_valid  out  1  one-cycle write-back strobe
wb_addr  out  4  destination register
wb_data  out  32  extracted/extended load data
err_valid  out  1  one-cycle error strobe
err_code  out  2  01 misaligned, 10 bad size, 11 timeout

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; op_ready=1.
  - mem_req, mem_we, wb_valid, err_valid = 0.
  - mem_addr, mem_be, mem_wdata, wb_addr, wb_data, err_code = 0; timeout counter = 0.
- Address: ea = op_base + sign_extend(op_offset), computed mod 2^32. mem_addr = {ea[31:2],2'b00}.
- Checks at accept:
  - size 11 -> err 10.
  - half with ea[0]=1 -> err 01.
  - word with ea[1:0]!=0 -> err 01.
  - When both checks fail, bad size takes priority.
- Lanes:
  - byte: be = 1<<ea[1:0]; wdata = byte replicated x4.
  - half: be = 0011 (ea[1]=0) or 1100; wdata = half replicated x2.
  - word: be = 1111.
  - mem_be is driven for loads too.
- Load extraction: select the addressed lane, then zero- or sign-extend per op_signed.
- FSM IDLE:
  - op_ready=1. Accept on op_valid&op_ready at edge E0.
  - Error -> err_valid=1 with code for the cycle after E0; stay IDLE, op_ready stays 1, no mem_req.
  - Otherwise latch all fields -> ACCESS.
- FSM ACCESS:
  - op_ready=0, mem_req=1, and mem_we/addr/be/wdata stable until ack.
  - At an edge with mem_ack=1:
    - Load: capture lane data -> WB.
    - Store: -> IDLE.
    - mem_req drops after that edge.
  - The counter increments each ACCESS cycle without ack. If the counter reaches TIMEOUT_CYCLES -> mem_req drops, err_valid with code 11 for one cycle, -> IDLE, no write-back.
  - An ack on the same edge as the timeout wins (transaction completes normally).
- FSM WB: wb_valid=1, wb_addr=latched dest, wb_data=extracted, for exactly one cycle -> IDLE.
- Latency:
  - Zero-wait load: accept E0, mem_req during cycle 1, ack at E1, wb_valid during cycle 2, op_ready high in cycle 3.
  - Zero-wait store: op_ready high in cycle 2.
- mem_ack outside ACCESS is ignored.
- wb_data and wb_addr hold their last value when wb_valid=0; err_code holds when err_valid=0.
- Register bank must gate its write with wb_valid.
- Reset mid-transaction: immediate return to IDLE; mem_req drops asynchronously; the pending op is lost, with no wb and no err.

Decomposition:
- Package mem_ctrl_pkg holds:
  - size encodings (SZ_BYTE/HALF/WORD) and error codes (ERR_MISALIGN/BADSIZE/TIMEOUT);
  - the state enum (IDLE, ACCESS, WB).
- One combinational sub-module, mem_lane_align:
  - inputs ea[1:0], size, signed, wdata, rdata;
  - outputs be, replicated wdata, extracted load data, misalign flag.
- The top level holds the FSM, latches and timeout counter.

Test Plan:
- Word load, base 0x100, offset +4, dest 5; ack after 2 wait cycles with rdata 0xDEADBEEF -> mem_addr 0x104, be 1111, we 0, mem_req 3 cycles, then wb_valid 1 cycle with wb_addr 5, wb_data 0xDEADBEEF.
- Byte store, base 0x203, offset 0, wdata 0x000000A5, zero-wait ack -> mem_addr 0x200, be 1000, mem_wdata 0xA5A5A5A5, we 1, no wb_valid, op_ready back 2 cycles after accept.
- Half load at base 0x10, offset -14 (ea 0x02), rdata 0x80011234:
  - signed -> be 1100, wb_data 0xFFFF8001;
  - unsigned -> 0x00008001.
- Half load at ea 0x101 -> err_valid 1 cycle, code 01, mem_req never asserted. Then size 11 at ea 0x101 -> code 10 (priority).
- Load with mem_ack held 0, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles then 0, err code 11, no wb_valid, op_ready 1. Repeat with ack on the 16th cycle -> normal wb, no error.
- rst_n low during ACCESS -> mem_req 0 before next edge, no wb/err. After release, op_ready 1 and a new word load completes normally.
